dram_result_streamer: RTL and testbench



---
 rtl/dram_result_streamer_pkg.sv | 19 +
 rtl/dram_result_streamer_start_edge_arbiter.sv | 40 ++++
 rtl/dram_result_streamer.sv | 148 ++++++++++++++
 tb/tb_dram_result_streamer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_result_streamer_pkg.sv
// Shared constants for the result-dump path: default widths, standard result window, FSM encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dram_result_streamer_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    localparam logic [15:0] RESULT_BASE  = 16'h0024;
    localparam int          RESULT_COUNT = 18;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/dram_result_streamer_start_edge_arbiter.sv
// Turns a start level into a one-cycle go pulse, deferring it while the matrix core owns the RAM.
// Latency: go in the same cycle as the rising edge (or the first cycle core_busy is low).
// Backpressure: edges while a dump is running are dropped; one edge is remembered while the core is busy.
module start_edge_arbiter (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic core_busy_i,
    input  logic busy_i,
    output logic go_o
);

    logic start_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    assign rise = start_i & ~start_q & ~busy_i;
    assign go_o = (rise | pend_q) & ~core_busy_i;

    always_comb begin
        pend_d = pend_q;
        if (go_o) begin
            pend_d = 1'b0;
        end else if (rise) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            start_q <= start_i;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/dram_result_streamer.sv
// Reads a window of result bytes from the shared data RAM and streams them out with a running checksum.
// Latency: one byte per RD_LAT+2 cycles with ready held high; read issued the cycle after go.
// Backpressure: a presented byte holds until ready; the next RAM read waits for the handshake.
module dram_result_streamer
    import dram_result_streamer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_core_busy,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_dram_read,
    output logic [ADDR_W-1:0] o_dram_addr,
    input  logic [DATA_W-1:0] i_dram_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [7:0]        o_checksum
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [CNT_W-1:0]  idx_q,   idx_d;
    logic [1:0]        lat_q,   lat_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              vld_q,   vld_d;
    logic [7:0]        chk_q,   chk_d;
    logic [CNT_W-1:0]  idx_next;
    logic              go;

    start_edge_arbiter u_arb (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .start_i     (i_start),
        .core_busy_i (i_core_busy),
        .busy_i      (o_busy),
        .go_o        (go)
    );

    assign idx_next = idx_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        data_d  = data_q;
        vld_d   = vld_q;
        chk_d   = chk_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    base_d = i_base_addr;
                    cnt_d  = i_count;
                    idx_d  = '0;
                    chk_d  = 8'h00;
                    if (i_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = i_base_addr;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                lat_d   = 2'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = i_dram_data;
                    vld_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    vld_d = 1'b0;
                    chk_d = chk_q + 8'(data_q);
                    idx_d = idx_next;
                    if (idx_q == cnt_q - CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        // Address wraps naturally at the top of the RAM.
                        addr_d  = base_q + ADDR_W'(idx_next);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            lat_q   <= 2'd0;
            addr_q  <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            chk_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            chk_q   <= chk_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_dram_read = (state_q == ST_ISSUE);
    assign o_dram_addr = addr_q;
    assign o_data      = data_q;
    assign o_valid     = vld_q;
    assign o_checksum  = chk_q;

endmodule

// File: tb/tb_dram_result_streamer.sv
// Bench for dram_result_streamer: RAM model, stream monitor and a queue-based model of the expected dump.
// Latency: n/a.
// Backpressure: i_ready either held high or randomised per cycle.
module tb_dram_result_streamer;
    import dram_result_streamer_pkg::*;

    localparam int RD_LAT = 1;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        i_core_busy;
    logic [15:0] i_base_addr;
    logic [7:0]  i_count;
    logic        o_busy;
    logic        o_done;
    logic        o_dram_read;
    logic [15:0] o_dram_addr;
    logic [7:0]  i_dram_data;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_checksum;

    dram_result_streamer #(.ADDR_W(16), .DATA_W(8), .CNT_W(8), .RD_LAT(RD_LAT)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_core_busy (i_core_busy),
        .i_base_addr (i_base_addr),
        .i_count     (i_count),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_dram_read (o_dram_read),
        .o_dram_addr (o_dram_addr),
        .i_dram_data (i_dram_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_checksum  (o_checksum)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // RAM: data returns RD_LAT cycles after the strobe; junk otherwise.
    logic [7:0] mem [0:65535];
    logic [7:0] rd_pipe [RD_LAT];
    always @(posedge i_clk) begin
        rd_pipe[0] <= o_dram_read ? mem[o_dram_addr] : 8'($urandom);
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign i_dram_data = rd_pipe[RD_LAT-1];

    logic [7:0]  got_q [$];
    int          acc_cyc [$];
    logic [15:0] rd_addr_q [$];
    int          rd_cyc [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          stab_err = 0;
    int          rd_busy_err = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold && !(o_valid && o_data == prev_data)) stab_err <= stab_err + 1;
            if (o_valid && i_ready) begin
                got_q.push_back(o_data);
                acc_cyc.push_back(cyc);
            end
            if (o_dram_read) begin
                rd_addr_q.push_back(o_dram_addr);
                rd_cyc.push_back(cyc);
                if (i_core_busy) rd_busy_err <= rd_busy_err + 1;
            end
            if (o_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            prev_hold <= o_valid && !i_ready;
            prev_data <= o_data;
        end
    end

    logic rand_rdy = 1'b0;
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            i_ready = rand_rdy ? (($urandom % 3) != 0) : 1'b1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    int g0, r0, d0, s0, b0, kick_cyc;

    task automatic kick(input logic [15:0] base, input logic [7:0] count);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        i_base_addr = base;
        i_count     = count;
        g0 = got_q.size();
        r0 = rd_addr_q.size();
        d0 = done_cnt;
        s0 = stab_err;
        b0 = rd_busy_err;
        kick_cyc = cyc;
        i_start = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
        repeat (6) @(negedge i_clk);
    endtask

    task automatic verify(input string tag, input logic [15:0] base, input int count,
                          input logic beat_chk, input int first_rd);
        logic [7:0] exp_b [$];
        int sum;
        int nb, nr, bad;
        sum = 0;
        for (int i = 0; i < count; i++) begin
            exp_b.push_back(mem[16'(base + 16'(i))]);
            sum += mem[16'(base + 16'(i))];
        end
        nb = got_q.size() - g0;
        nr = rd_addr_q.size() - r0;
        check({tag, "_nbytes"}, 64'(nb), 64'(count));
        check({tag, "_nreads"}, 64'(nr), 64'(count));
        for (int i = 0; i < count && i < nb; i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(got_q[g0+i]), 64'(exp_b[i]));
        for (int i = 0; i < count && i < nr; i++)
            check($sformatf("%s_addr%0d", tag, i), 64'(rd_addr_q[r0+i]), 64'(16'(base + 16'(i))));
        check({tag, "_checksum"}, 64'(o_checksum), 64'(sum % 256));
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_busy_after"}, 64'(o_busy), 64'd0);
        check({tag, "_stable_hold"}, 64'(stab_err - s0), 64'd0);
        check({tag, "_rd_while_core_busy"}, 64'(rd_busy_err - b0), 64'd0);
        if (first_rd >= 0 && nr > 0)
            check({tag, "_first_rd_cycle"}, 64'(rd_cyc[r0]), 64'(first_rd));
        if (beat_chk && nb > 1) begin
            bad = 0;
            for (int i = 1; i < nb; i++)
                if (acc_cyc[g0+i] - acc_cyc[g0+i-1] != RD_LAT + 2) bad++;
            check({tag, "_beat_period"}, 64'(bad), 64'd0);
        end
    endtask

    logic [7:0] std_win [RESULT_COUNT] = '{8'h7C, 8'h2D, 8'hC2, 8'h49, 8'hC4, 8'h31, 8'h44, 8'h43, 8'hCB,
                                         8'h58, 8'h69, 8'h5F, 8'hDC, 8'h7D, 8'h1F, 8'hB1, 8'hBF, 8'hC7};

    initial begin
        int n, drop_cyc, cnt;
        logic [15:0] base;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < RESULT_COUNT; i++) mem[RESULT_BASE + 16'(i)] = std_win[i];

        i_rst = 1'b1; i_start = 1'b0; i_core_busy = 1'b0;
        i_base_addr = 16'h0; i_count = 8'h0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_outputs", {o_busy, o_done, o_dram_read, o_dram_addr, o_data, o_valid, o_checksum}, 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check("idle_busy", 64'(o_busy), 64'd0);

        // Standard window, ready always high.
        kick(RESULT_BASE, 8'(RESULT_COUNT));
        wait_done("std");
        verify("std", RESULT_BASE, RESULT_COUNT, 1'b1, kick_cyc + 1);
        check("std_checksum_ca", 64'(o_checksum), 64'hCA);

        // Standard window, random backpressure.
        rand_rdy = 1'b1;
        kick(RESULT_BASE, 8'(RESULT_COUNT));
        wait_done("bp");
        verify("bp", RESULT_BASE, RESULT_COUNT, 1'b0, kick_cyc + 1);
        check("bp_checksum_ca", 64'(o_checksum), 64'hCA);
        rand_rdy = 1'b0;

        // Start while the core is busy, plus a second edge during the dump.
        @(posedge i_clk); #1;
        i_core_busy = 1'b1;
        kick(RESULT_BASE, 8'(RESULT_COUNT));
        repeat (20) @(posedge i_clk);
        #1;
        check("corebusy_no_reads", 64'(rd_addr_q.size() - r0), 64'd0);
        check("corebusy_not_busy", 64'(o_busy), 64'd0);
        @(posedge i_clk); #1;
        i_core_busy = 1'b0;
        drop_cyc = cyc;
        repeat (10) @(posedge i_clk);
        #1; i_start = 1'b0;
        @(posedge i_clk); #1; i_start = 1'b1;
        wait_done("cb");
        repeat (10) @(negedge i_clk);
        verify("cb", RESULT_BASE, RESULT_COUNT, 1'b1, drop_cyc + 1);

        // Empty dump.
        kick(16'h0100, 8'd0);
        wait_done("zero");
        verify("zero", 16'h0100, 0, 1'b0, -1);
        check("zero_done_latency", 64'(done_cyc - kick_cyc), 64'd1);

        // Address wrap at the top of the RAM.
        kick(16'hFFFE, 8'd4);
        wait_done("wrap");
        verify("wrap", 16'hFFFE, 4, 1'b1, kick_cyc + 1);

        // Reset after the fifth byte, then a fresh full dump.
        kick(RESULT_BASE, 8'(RESULT_COUNT));
        n = 0;
        while (got_q.size() - g0 < 5 && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        check("rst_five_bytes", 64'(got_q.size() - g0), 64'd5);
        check("rst_busy_before", 64'(o_busy), 64'd1);
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        #1;
        check("rst_outputs", {o_busy, o_done, o_dram_read, o_dram_addr, o_data, o_valid, o_checksum}, 64'd0);
        i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #1; i_rst = 1'b0;
        repeat (30) @(negedge i_clk);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_idle", 64'(o_busy), 64'd0);
        kick(RESULT_BASE, 8'(RESULT_COUNT));
        wait_done("post_rst");
        verify("post_rst", RESULT_BASE, RESULT_COUNT, 1'b1, kick_cyc + 1);
        check("post_rst_checksum_ca", 64'(o_checksum), 64'hCA);

        // Random windows and backpressure.
        for (int t = 0; t < 6; t++) begin
            base = 16'($urandom);
            cnt  = $urandom_range(1, 30);
            rand_rdy = 1'($urandom_range(0, 1));
            kick(base, 8'(cnt));
            wait_done($sformatf("rnd%0d", t));
            verify($sformatf("rnd%0d", t), base, cnt, !rand_rdy, kick_cyc + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
